// File: rtl/test_pkg.sv
`timescale 1ns/1ps
// Shared types and constants for the test_core frame generator.
package test_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    ACK      = 2'd1,
    WAIT_ADC = 2'd2,
    SCAN     = 2'd3
  } state_t;

  localparam int NCH = 16;
  localparam int STEP_W = $clog2(NCH);
  localparam logic [15:0] DEFAULT_LFSR_SEED = 16'hACE1;

  // Feedback taps of x^16+x^14+x^13+x^11+1 (Fibonacci form, shift toward MSB).
  localparam int TAP_A = 15;
  localparam int TAP_B = 13;
  localparam int TAP_C = 12;
  localparam int TAP_D = 10;

  function automatic logic [15:0] lfsr_step(input logic [15:0] cur);
    return {cur[14:0], cur[TAP_A] ^ cur[TAP_B] ^ cur[TAP_C] ^ cur[TAP_D]};
  endfunction

endpackage

// File: rtl/test_core_sync_edge.sv
`timescale 1ns/1ps
// Multi-stage synchronizer plus rising-edge detector for the adc_rxc strobe.
// An edge is reported only once the synchronized level has been seen low
// after reset, so a strobe already high at reset release is not a frame.
module sync_edge #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic async_in,
  output logic rise
);

  logic [STAGES-1:0] chain_reg;
  logic [STAGES-1:0] valid_reg;
  logic              prev_reg;
  logic              armed_reg;
  logic              sync_out;

  assign sync_out = chain_reg[STAGES-1];

  // Synchronizer chain, fill tracker, edge history and low-seen arming.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      chain_reg <= '0;
      valid_reg <= '0;
      prev_reg  <= 1'b0;
      armed_reg <= 1'b0;
    end else begin
      chain_reg <= {chain_reg[STAGES-2:0], async_in};
      valid_reg <= {valid_reg[STAGES-2:0], 1'b1};
      prev_reg  <= sync_out;
      if (valid_reg[STAGES-1] && !sync_out) begin
        armed_reg <= 1'b1;
      end
    end
  end

  assign rise = armed_reg & sync_out & ~prev_reg;

endmodule

// File: rtl/test_core.sv
`timescale 1ns/1ps
// Command-driven frame pattern generator: on each adc_rxc frame it latches a
// 64-bit word and sequence number per channel, then strobes the channels in turn.
module test_core
  import test_pkg::*;
#(
  parameter int          SYNC_STAGES = 2,
  parameter logic [15:0] LFSR_SEED   = DEFAULT_LFSR_SEED
) (
  input  logic        sys_clk,
  input  logic        rst,
  input  logic        gmii_txc,
  input  logic        gmii_rxc,
  input  logic        fifo_clk,
  input  logic        adc_rxc,
  input  logic        cmd_make,
  output logic        cmd_done,
  output logic [63:0] sol0, sol1, sol2, sol3, sol4, sol5, sol6, sol7,
  output logic [63:0] sol8, sol9, solA, solB, solC, solD, solE, solF,
  output logic [7:0]  sos0, sos1, sos2, sos3, sos4, sos5, sos6, sos7,
  output logic [7:0]  sos8, sos9, sosA, sosB, sosC, sosD, sosE, sosF,
  output logic        sob0, sob1, sob2, sob3, sob4, sob5, sob6, sob7,
  output logic        sob8, sob9, sobA, sobB, sobC, sobD, sobE, sobF
);

  // Compatibility-only inputs; intentionally not used by any logic.
  logic unused_inputs;
  assign unused_inputs = gmii_txc ^ gmii_rxc ^ fifo_clk;

  state_t              state_reg, state_next;
  logic [31:0]         frame_cnt_reg;
  logic [15:0]         lfsr_reg;
  logic [STEP_W-1:0]   step_reg;
  logic                cmd_armed_reg;
  logic                frame_event;
  logic                cmd_fresh;
  logic                accept;
  logic                capture;
  logic                scan_last;
  logic [63:0]         sol_reg [NCH];
  logic [7:0]          sos_reg [NCH];
  logic [NCH-1:0]      sob_vec;

  sync_edge #(
    .STAGES (SYNC_STAGES)
  ) u_sync_edge (
    .clk      (sys_clk),
    .rst      (rst),
    .async_in (adc_rxc),
    .rise     (frame_event)
  );

  // A command counts only if cmd_make was seen low since the last acceptance.
  assign cmd_fresh = cmd_make & cmd_armed_reg;

  // State register.
  always_ff @(posedge sys_clk or posedge rst) begin
    if (rst) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Next-state and control decode; a fresh command always wins over frames.
  always_comb begin
    state_next = state_reg;
    cmd_done   = 1'b0;
    accept     = 1'b0;
    capture    = 1'b0;
    scan_last  = 1'b0;
    case (state_reg)
      IDLE: begin
        if (cmd_fresh) begin
          accept     = 1'b1;
          state_next = ACK;
        end
      end
      ACK: begin
        cmd_done   = 1'b1;
        state_next = WAIT_ADC;
      end
      WAIT_ADC: begin
        if (cmd_fresh) begin
          accept     = 1'b1;
          state_next = ACK;
        end else if (frame_event) begin
          capture    = 1'b1;
          state_next = SCAN;
        end
      end
      SCAN: begin
        if (cmd_fresh) begin
          accept     = 1'b1;
          state_next = ACK;
        end else if (step_reg == STEP_W'(NCH - 1)) begin
          scan_last  = 1'b1;
          state_next = WAIT_ADC;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Command re-arm: cleared on acceptance, set again once cmd_make drops.
  always_ff @(posedge sys_clk or posedge rst) begin
    if (rst) begin
      cmd_armed_reg <= 1'b1;
    end else if (accept) begin
      cmd_armed_reg <= 1'b0;
    end else if (!cmd_make) begin
      cmd_armed_reg <= 1'b1;
    end
  end

  // Frame counter, pattern LFSR and scan step index.
  always_ff @(posedge sys_clk or posedge rst) begin
    if (rst) begin
      frame_cnt_reg <= '0;
      lfsr_reg      <= LFSR_SEED;
      step_reg      <= '0;
    end else begin
      if (state_reg == ACK) begin
        frame_cnt_reg <= '0;
        lfsr_reg      <= LFSR_SEED;
      end else if (scan_last) begin
        frame_cnt_reg <= frame_cnt_reg + 32'd1;
        lfsr_reg      <= lfsr_step(lfsr_reg);
      end
      if (capture) begin
        step_reg <= '0;
      end else if (state_reg == SCAN) begin
        step_reg <= step_reg + STEP_W'(1);
      end
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < NCH; gi++) begin : g_chan
      // Per-channel word and sequence capture on a frame; held otherwise.
      always_ff @(posedge sys_clk or posedge rst) begin
        if (rst) begin
          sol_reg[gi] <= '0;
          sos_reg[gi] <= '0;
        end else if (capture) begin
          sol_reg[gi] <= {frame_cnt_reg, 8'(gi), 8'h00, lfsr_reg};
          sos_reg[gi] <= frame_cnt_reg[7:0];
        end
      end
    end
  endgenerate

  // One-hot channel strobe derived from the scan step.
  assign sob_vec = (state_reg == SCAN) ? ({{(NCH-1){1'b0}}, 1'b1} << step_reg) : '0;

  assign sol0 = sol_reg[0];   assign sol1 = sol_reg[1];
  assign sol2 = sol_reg[2];   assign sol3 = sol_reg[3];
  assign sol4 = sol_reg[4];   assign sol5 = sol_reg[5];
  assign sol6 = sol_reg[6];   assign sol7 = sol_reg[7];
  assign sol8 = sol_reg[8];   assign sol9 = sol_reg[9];
  assign solA = sol_reg[10];  assign solB = sol_reg[11];
  assign solC = sol_reg[12];  assign solD = sol_reg[13];
  assign solE = sol_reg[14];  assign solF = sol_reg[15];

  assign sos0 = sos_reg[0];   assign sos1 = sos_reg[1];
  assign sos2 = sos_reg[2];   assign sos3 = sos_reg[3];
  assign sos4 = sos_reg[4];   assign sos5 = sos_reg[5];
  assign sos6 = sos_reg[6];   assign sos7 = sos_reg[7];
  assign sos8 = sos_reg[8];   assign sos9 = sos_reg[9];
  assign sosA = sos_reg[10];  assign sosB = sos_reg[11];
  assign sosC = sos_reg[12];  assign sosD = sos_reg[13];
  assign sosE = sos_reg[14];  assign sosF = sos_reg[15];

  assign sob0 = sob_vec[0];   assign sob1 = sob_vec[1];
  assign sob2 = sob_vec[2];   assign sob3 = sob_vec[3];
  assign sob4 = sob_vec[4];   assign sob5 = sob_vec[5];
  assign sob6 = sob_vec[6];   assign sob7 = sob_vec[7];
  assign sob8 = sob_vec[8];   assign sob9 = sob_vec[9];
  assign sobA = sob_vec[10];  assign sobB = sob_vec[11];
  assign sobC = sob_vec[12];  assign sobD = sob_vec[13];
  assign sobE = sob_vec[14];  assign sobF = sob_vec[15];

endmodule

// File: tb/tb_test_core.sv
`timescale 1ns/1ps
// Directed self-checking bench for test_core.
module tb_test_core;
  import test_pkg::*;

  logic        sys_clk = 1'b0;
  logic        rst;
  logic        gmii_txc = 1'b0;
  logic        gmii_rxc = 1'b0;
  logic        fifo_clk = 1'b0;
  logic        adc_rxc;
  logic        cmd_make;
  logic        cmd_done;
  logic [63:0] sol [16];
  logic [7:0]  sos [16];
  logic [15:0] sob_v;

  int   n_assert = 0;
  int   n_fail   = 0;
  logic sob_any;
  int   done_cnt;
  int   lat;

  always #5 sys_clk = ~sys_clk;

  test_core dut (
    .sys_clk (sys_clk), .rst (rst),
    .gmii_txc (gmii_txc), .gmii_rxc (gmii_rxc), .fifo_clk (fifo_clk),
    .adc_rxc (adc_rxc), .cmd_make (cmd_make), .cmd_done (cmd_done),
    .sol0 (sol[0]),  .sol1 (sol[1]),  .sol2 (sol[2]),  .sol3 (sol[3]),
    .sol4 (sol[4]),  .sol5 (sol[5]),  .sol6 (sol[6]),  .sol7 (sol[7]),
    .sol8 (sol[8]),  .sol9 (sol[9]),  .solA (sol[10]), .solB (sol[11]),
    .solC (sol[12]), .solD (sol[13]), .solE (sol[14]), .solF (sol[15]),
    .sos0 (sos[0]),  .sos1 (sos[1]),  .sos2 (sos[2]),  .sos3 (sos[3]),
    .sos4 (sos[4]),  .sos5 (sos[5]),  .sos6 (sos[6]),  .sos7 (sos[7]),
    .sos8 (sos[8]),  .sos9 (sos[9]),  .sosA (sos[10]), .sosB (sos[11]),
    .sosC (sos[12]), .sosD (sos[13]), .sosE (sos[14]), .sosF (sos[15]),
    .sob0 (sob_v[0]),  .sob1 (sob_v[1]),  .sob2 (sob_v[2]),  .sob3 (sob_v[3]),
    .sob4 (sob_v[4]),  .sob5 (sob_v[5]),  .sob6 (sob_v[6]),  .sob7 (sob_v[7]),
    .sob8 (sob_v[8]),  .sob9 (sob_v[9]),  .sobA (sob_v[10]), .sobB (sob_v[11]),
    .sobC (sob_v[12]), .sobD (sob_v[13]), .sobE (sob_v[14]), .sobF (sob_v[15])
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Advance n cycles, recording any strobe and counting cmd_done pulses.
  task automatic step_mon(input int n);
    repeat (n) begin
      @(negedge sys_clk);
      sob_any  = sob_any | (|sob_v);
      done_cnt = done_cnt + int'(cmd_done);
    end
  endtask

  // Bounded wait for the first strobe of a scan; returns cycles waited.
  task automatic wait_sob0(input string tag, output int cycles);
    cycles = 0;
    while (sob_v[0] !== 1'b1 && cycles < 200) begin
      @(negedge sys_clk);
      cycles++;
    end
    check({tag, " sob0 arrived"}, 64'(cycles < 200), 64'd1);
  endtask

  // Called with sob0 visible: walk the 16 steps, then expect WAIT_ADC.
  task automatic scan_check(input string tag);
    logic [15:0] exp_v;
    for (int k = 0; k < 16; k++) begin
      exp_v = 16'h0001 << k;
      check($sformatf("%s sob step %0d", tag, k), 64'(sob_v), 64'(exp_v));
      if (k < 15) @(negedge sys_clk);
    end
    @(negedge sys_clk);
    check({tag, " sob idle after scan"}, 64'(sob_v), 64'd0);
    check({tag, " state after scan"}, 64'(dut.state_reg), 64'(WAIT_ADC));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; adc_rxc = 1'b0; cmd_make = 1'b0;
    sob_any = 1'b0; done_cnt = 0; lat = 0;

    // Reset held 100 ns.
    repeat (10) @(negedge sys_clk);
    check("rst sol3", sol[3], 64'd0);
    check("rst solF", sol[15], 64'd0);
    check("rst sos0", 64'(sos[0]), 64'd0);
    check("rst sob", 64'(sob_v), 64'd0);
    check("rst cmd_done", 64'(cmd_done), 64'd0);
    check("rst state", 64'(dut.state_reg), 64'(IDLE));
    rst = 1'b0;

    // adc pulses with no command: nothing happens.
    for (int p = 0; p < 3; p++) begin
      adc_rxc = 1'b1; step_mon(5);
      adc_rxc = 1'b0; step_mon(5);
    end
    check("idle sob", 64'(sob_any), 64'd0);
    check("idle cmd_done", 64'(done_cnt), 64'd0);
    check("idle sol0", sol[0], 64'd0);
    check("idle sos0", 64'(sos[0]), 64'd0);

    // Held command: exactly one acknowledge, one cycle later.
    cmd_make = 1'b1;
    done_cnt = 0;
    @(negedge sys_clk);
    check("cmd_done latency", 64'(cmd_done), 64'd1);
    done_cnt = 1;
    step_mon(20);
    check("cmd_done single", 64'(done_cnt), 64'd1);
    check("state after cmd", 64'(dut.state_reg), 64'(WAIT_ADC));
    cmd_make = 1'b0;
    step_mon(2);

    // Frame 1.
    adc_rxc = 1'b1;
    wait_sob0("f1", lat);
    check("f1 latency", 64'(lat), 64'd3);
    adc_rxc = 1'b0;
    check("f1 sol3", sol[3], 64'h0000_0000_0300_ACE1);
    check("f1 sos3", 64'(sos[3]), 64'h00);
    check("f1 sol0", sol[0], 64'h0000_0000_0000_ACE1);
    scan_check("f1");

    // Frame 2, 30 us later.
    repeat (3000) @(negedge sys_clk);
    adc_rxc = 1'b1;
    wait_sob0("f2", lat);
    adc_rxc = 1'b0;
    check("f2 solF", sol[15], 64'h0000_0001_0F00_59C3);
    check("f2 sol0", sol[0], 64'h0000_0001_0000_59C3);
    for (int n = 0; n < 16; n++) begin
      check($sformatf("f2 sos%0d", n), 64'(sos[n]), 64'h01);
    end
    scan_check("f2");

    // Frame 3.
    repeat (200) @(negedge sys_clk);
    adc_rxc = 1'b1;
    wait_sob0("f3", lat);
    adc_rxc = 1'b0;
    check("f3 sol5", sol[5], 64'h0000_0002_0500_B387);
    check("f3 sos7", 64'(sos[7]), 64'h02);
    scan_check("f3");
    repeat (20) @(negedge sys_clk);
    check("f3 sol5 held", sol[5], 64'h0000_0002_0500_B387);

    // Re-command restarts the count and the LFSR.
    cmd_make = 1'b1;
    @(negedge sys_clk);
    check("recmd cmd_done", 64'(cmd_done), 64'd1);
    cmd_make = 1'b0;
    @(negedge sys_clk);
    check("recmd cmd_done low", 64'(cmd_done), 64'd0);
    adc_rxc = 1'b1;
    wait_sob0("f4", lat);
    adc_rxc = 1'b0;
    check("f4 sol0", sol[0], 64'h0000_0000_0000_ACE1);
    check("f4 sos0", 64'(sos[0]), 64'h00);

    // Abort with reset at scan step 7.
    repeat (7) @(negedge sys_clk);
    check("f4 sob step 7", 64'(sob_v), 64'h0080);
    rst = 1'b1;
    #1;
    check("abort sob", 64'(sob_v), 64'd0);
    check("abort sol0", sol[0], 64'd0);
    check("abort solF", sol[15], 64'd0);
    check("abort sos0", 64'(sos[0]), 64'd0);
    check("abort cmd_done", 64'(cmd_done), 64'd0);
    check("abort state", 64'(dut.state_reg), 64'(IDLE));
    adc_rxc = 1'b1;
    repeat (3) @(negedge sys_clk);

    // Release with adc_rxc already high: no frame until it goes low.
    rst = 1'b0;
    cmd_make = 1'b1;
    @(negedge sys_clk);
    check("post-rst cmd_done", 64'(cmd_done), 64'd1);
    cmd_make = 1'b0;
    sob_any = 1'b0;
    step_mon(20);
    check("post-rst no sob", 64'(sob_any), 64'd0);
    adc_rxc = 1'b0;
    repeat (5) @(negedge sys_clk);
    adc_rxc = 1'b1;
    wait_sob0("f5", lat);
    check("f5 latency", 64'(lat), 64'd3);
    adc_rxc = 1'b0;
    check("f5 sol9", sol[9], 64'h0000_0000_0900_ACE1);
    scan_check("f5");

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
